cache_replace_ctrl: RTL and testbench
=====================================

// Module: cache_replace_ctrl
// PURPOSE
//  Replacement/refill sequencer for the 4-way set-associative cache. Owns one
//  true-LRU stack per set. Takes one lookup result per transaction (hit/miss
//  plus valid/dirty masks), picks the victim way and runs writeback then refill
//  handshakes. Updates LRU state and returns the chosen way.
//  Sits between the tag-compare stage and the memory-side interface.
// PARAMETERS
//  NUM_SETS  64  number of cache sets (power of 2, >=2)
//  SET_W     6   set index width, = log2(NUM_SETS)
// PORTS
//  clk            in   1      clock
//  rst_b          in   1      reset, asynchronous, active-low
//  req_valid      in   1      lookup result valid
//  req_ready      out  1      controller can accept (IDLE only)
//  req_set        in   SET_W  set index of lookup
//  req_hit        in   1      tag hit
//  req_way        in   2      hit way (meaningful when req_hit)
//  req_vmask      in   4      per-way valid bits of req_set
//  req_dmask      in   4      per-way dirty bits of req_set
//  rsp_valid      out  1      1-cycle pulse: transaction complete
//  rsp_way        out  2      way hit or filled
//  rsp_evict      out  1      with rsp_valid: a dirty line was written back
//  wb_req         out  1      writeback request, held until wb_ack
//  wb_set/wb_way  out  SET_W/2  location being written back
//  wb_ack         in   1      writeback done
//  fill_req       out  1      refill request, held until fill_ack
//  fill_set/fill_way out SET_W/2 location being filled
//  fill_ack       in   1      refill done
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready=1. FSM=IDLE. Every set's stack is
//    MRU->LRU = {0,1,2,3}, so LRU way = 3.
//  - States: IDLE, HIT, VICTIM, WB, FILL, DONE.
//  - IDLE: req_ready=1. On req_valid, latch set/hit/way/masks. Go to HIT
//    if req_hit, otherwise VICTIM. Then req_ready=0 until back in IDLE.
//  - HIT (1 cycle): set's stack updated with req_way. rsp_valid=1,
//    rsp_way=req_way, rsp_evict=0 -> IDLE. Latency accept->rsp = 1 cycle.
//    req_vmask is not checked on a hit.
//  - VICTIM (1 cycle): victim = lowest-index way with vmask bit 0. If all ways
//    are valid, victim = the set's LRU way. Go to WB if victim is valid and
//    dirty, otherwise to FILL.
//  - WB: wb_req=1, wb_set/wb_way stable. On wb_ack -> FILL; also set the
//    evict flag.
//  - FILL: fill_req=1. On fill_ack -> DONE.
//  - DONE (1 cycle): stack updated with victim. rsp_valid=1, rsp_way=victim,
//    rsp_evict=evict flag -> IDLE.
//  - LRU update: accessed way moves to MRU. Ways that were more recent than it
//    shift down one position; less recent ways are unchanged. Only the latched
//    set changes. At most one set is updated per cycle.
//  - Ack handling: wb_req/fill_req deassert the cycle after ack is sampled.
//    An ack in the same cycle as req's first assertion counts. An ack in any
//    other state is ignored. Simultaneous wb_ack+fill_ack in WB: only wb_ack
//    counts, and FILL still asserts fill_req for at least one cycle.
//  - rst_b asserted mid-transaction (any state): immediate return to reset
//    values. The in-flight transaction is dropped with no rsp_valid, and all
//    stacks are reinitialised.
//  - Back-to-back: the next request is accepted the cycle after rsp_valid.
//    Minimum miss turnaround is 4 cycles (VICTIM, FILL with same-cycle ack,
//    DONE, IDLE).
// CONFIGURATION
//  CACHE_REPL_PERF_EN defined: adds outputs hit_cnt[31:0], miss_cnt[31:0],
//  wb_cnt[31:0]. hit_cnt increments at HIT; miss_cnt at VICTIM; wb_cnt at
//  wb_ack in WB. All reset to 0 and wrap at 2^32.
//  Undefined: ports and counters absent; functionality otherwise identical.
// STRUCTURE
//  - cache_pkg: NUM_WAYS=4, WAY_W=2, FSM state encoding, lru_stack_t (4x2-bit)
//    and its reset constant.
//  - One sub-module lru_set_array: NUM_SETS stacks with a read port
//    (set -> LRU way) and an update port (en, set, way). Registers only,
//    async reset.
// TESTING
//  1 reset; miss set 0, vmask=0000 -> VICTIM picks way 0, no wb_req,
//    fill_req until fill_ack; rsp_way=0, rsp_evict=0.
//  2 set 5, vmask=1111, dmask=0, hits on ways 0,1,2,3 in order; then miss ->
//    victim way 0 (LRU); a repeated hit on way 0 first makes the victim way 1.
//  3 miss set 3, vmask=1111, dmask=1111, LRU way 3 -> wb_req, wb_way=3;
//    wb_ack after 3 cycles; then fill_req; rsp_evict=1, rsp_way=3.
//  4 hit at req_valid with req_ready=1 -> rsp_valid exactly one cycle later.
//    Stray fill_ack in IDLE -> no effect.
//  5 rst_b low during WB -> wb_req=0 at once, no rsp_valid; next miss on that
//    set with all ways valid and clean -> victim way 3.
//  6 (PERF_EN) 2 hits, 1 clean miss, 1 dirty miss -> hit_cnt=2,
//    miss_cnt=2, wb_cnt=1.

Source files
------------

// File: rtl/cache_replace_ctrl_pkg.sv
// Shared types for the cache replacement sequencer: way width, FSM states,
// and the per-set true-LRU stack together with its update and search helpers.
package cache_pkg;

  localparam int NUM_WAYS = 4;
  localparam int WAY_W    = 2;

  typedef logic [WAY_W-1:0] way_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HIT,
    ST_VICTIM,
    ST_WB,
    ST_FILL,
    ST_DONE
  } state_e;

  // Element [0] is the MRU way and element [NUM_WAYS-1] is the LRU way.
  typedef way_t [NUM_WAYS-1:0] lru_stack_t;

  localparam lru_stack_t LRU_STACK_RST = {2'd3, 2'd2, 2'd1, 2'd0};

  typedef struct packed {
    logic found;
    way_t way;
  } free_way_t;

  // Move w to MRU. Entries above w's old position shift down by one;
  // entries below it keep their positions.
  function automatic lru_stack_t lru_touch(lru_stack_t s, way_t w);
    lru_stack_t r;
    logic       found;
    r     = s;
    r[0]  = w;
    found = (s[0] == w);
    for (int i = 1; i < NUM_WAYS; i++) begin
      if (!found) r[i] = s[i-1];
      if (s[i] == w) found = 1'b1;
    end
    return r;
  endfunction

  // Lowest-index invalid way, if any.
  function automatic free_way_t find_free(logic [NUM_WAYS-1:0] vmask);
    free_way_t r;
    r = '0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (!vmask[i]) begin
        r.found = 1'b1;
        r.way   = way_t'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/cache_replace_ctrl_if.sv
// Lookup, response, writeback and refill signals of the replacement sequencer.
// master = tag-compare/memory side, slave = cache_replace_ctrl.
interface cache_replace_ctrl_if #(parameter int SET_W = 6) ();

  logic             req_valid;
  logic             req_ready;
  logic [SET_W-1:0] req_set;
  logic             req_hit;
  logic [1:0]       req_way;
  logic [3:0]       req_vmask;
  logic [3:0]       req_dmask;

  logic             rsp_valid;
  logic [1:0]       rsp_way;
  logic             rsp_evict;

  logic             wb_req;
  logic [SET_W-1:0] wb_set;
  logic [1:0]       wb_way;
  logic             wb_ack;

  logic             fill_req;
  logic [SET_W-1:0] fill_set;
  logic [1:0]       fill_way;
  logic             fill_ack;

  modport master (
    output req_valid, req_set, req_hit, req_way, req_vmask, req_dmask,
    output wb_ack, fill_ack,
    input  req_ready, rsp_valid, rsp_way, rsp_evict,
    input  wb_req, wb_set, wb_way, fill_req, fill_set, fill_way
  );

  modport slave (
    input  req_valid, req_set, req_hit, req_way, req_vmask, req_dmask,
    input  wb_ack, fill_ack,
    output req_ready, rsp_valid, rsp_way, rsp_evict,
    output wb_req, wb_set, wb_way, fill_req, fill_set, fill_way
  );

endinterface

// File: rtl/cache_replace_ctrl_lru.sv
// lru_set_array: one true-LRU stack per set, a read port returning the set's
// LRU way and a single update port that moves one way to MRU.
module lru_set_array
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int SET_W    = 6
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic [SET_W-1:0] rd_set_i,
  output way_t             rd_lru_way_o,
  input  logic             upd_en_i,
  input  logic [SET_W-1:0] upd_set_i,
  input  way_t             upd_way_i
);

  lru_stack_t stack_q [NUM_SETS];

  // NOTE: this array is flops, not RAM, so every entry can and must take the
  // reset value; a mid-transaction reset reinitialises all stacks at once.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int s = 0; s < NUM_SETS; s++) stack_q[s] <= LRU_STACK_RST;
    end else if (upd_en_i) begin
      stack_q[upd_set_i] <= lru_touch(stack_q[upd_set_i], upd_way_i);
    end
  end

  assign rd_lru_way_o = stack_q[rd_set_i][NUM_WAYS-1];

endmodule

// File: rtl/cache_replace_ctrl.sv
// Replacement/refill sequencer: picks a victim, runs writeback then refill,
// updates LRU. Define CACHE_REPL_PERF_EN to add hit/miss/writeback counters.
module cache_replace_ctrl
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int SET_W    = $clog2(NUM_SETS)
) (
  input  logic                clk,
  input  logic                rst_b,
  cache_replace_ctrl_if.slave bus
`ifdef CACHE_REPL_PERF_EN
  ,
  output logic [31:0]         hit_cnt_o,
  output logic [31:0]         miss_cnt_o,
  output logic [31:0]         wb_cnt_o
`endif
);

  state_e           state_q, state_d;
  logic [SET_W-1:0] set_q, set_d;
  way_t             way_q, way_d;
  logic [3:0]       vmask_q, vmask_d;
  logic [3:0]       dmask_q, dmask_d;
  logic             evict_q, evict_d;

  logic             upd_en;
  way_t             lru_way;
  way_t             victim;
  free_way_t        free_way;

  lru_set_array #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) u_lru (
    .clk          (clk),
    .rst_b        (rst_b),
    .rd_set_i     (set_q),
    .rd_lru_way_o (lru_way),
    .upd_en_i     (upd_en),
    .upd_set_i    (set_q),
    .upd_way_i    (way_q)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its peers, regardless of statement order.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      set_q   <= '0;
      way_q   <= '0;
      vmask_q <= '0;
      dmask_q <= '0;
      evict_q <= 1'b0;
    end else begin
      state_q <= state_d;
      set_q   <= set_d;
      way_q   <= way_d;
      vmask_q <= vmask_d;
      dmask_q <= dmask_d;
      evict_q <= evict_d;
    end
  end

  always_comb begin
    free_way = find_free(vmask_q);
    victim   = free_way.found ? free_way.way : lru_way;
  end

  assign bus.wb_set   = set_q;
  assign bus.wb_way   = way_q;
  assign bus.fill_set = set_q;
  assign bus.fill_way = way_q;

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    set_d         = set_q;
    way_d         = way_q;
    vmask_d       = vmask_q;
    dmask_d       = dmask_q;
    evict_d       = evict_q;
    upd_en        = 1'b0;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_way   = '0;
    bus.rsp_evict = 1'b0;
    bus.wb_req    = 1'b0;
    bus.fill_req  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        evict_d       = 1'b0;
        if (bus.req_valid) begin
          set_d   = bus.req_set;
          way_d   = bus.req_way;
          vmask_d = bus.req_vmask;
          dmask_d = bus.req_dmask;
          state_d = bus.req_hit ? ST_HIT : ST_VICTIM;
        end
      end
      ST_HIT: begin
        upd_en        = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_way   = way_q;
        state_d       = ST_IDLE;
      end
      ST_VICTIM: begin
        way_d   = victim;
        state_d = (vmask_q[victim] && dmask_q[victim]) ? ST_WB : ST_FILL;
      end
      ST_WB: begin
        bus.wb_req = 1'b1;
        if (bus.wb_ack) begin
          evict_d = 1'b1;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        bus.fill_req = 1'b1;
        if (bus.fill_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        upd_en        = 1'b1;
        bus.rsp_valid = 1'b1;
        bus.rsp_way   = way_q;
        bus.rsp_evict = evict_q;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef CACHE_REPL_PERF_EN
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      wb_cnt_o   <= '0;
    end else begin
      if (state_q == ST_HIT)              hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (state_q == ST_VICTIM)           miss_cnt_o <= miss_cnt_o + 32'd1;
      if (state_q == ST_WB && bus.wb_ack) wb_cnt_o   <= wb_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_replace_ctrl.sv
// Self-checking bench for cache_replace_ctrl: directed scenarios plus random
// transactions against a timestamp-based LRU reference model.
module tb_cache_replace_ctrl;

  localparam int NUM_SETS = 64;
  localparam int SET_W    = 6;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  cache_replace_ctrl_if #(.SET_W(SET_W)) bus ();

`ifdef CACHE_REPL_PERF_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  cache_replace_ctrl #(
    .NUM_SETS (NUM_SETS),
    .SET_W    (SET_W)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
`ifdef CACHE_REPL_PERF_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt),
    .wb_cnt_o   (wb_cnt)
`endif
  );

  // Reference model: last-use timestamp per way; the LRU way is the oldest.
  int ts [NUM_SETS][4];
  int tnow;

  function automatic void model_reset();
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < 4; w++) ts[s][w] = 3 - w;
    tnow = 4;
  endfunction

  function automatic int model_lru(int s);
    int best = 0;
    for (int w = 1; w < 4; w++) if (ts[s][w] < ts[s][best]) best = w;
    return best;
  endfunction

  function automatic void model_touch(int s, int w);
    ts[s][w] = tnow;
    tnow++;
  endfunction

  task automatic idle_inputs();
    bus.req_valid = 1'b0;
    bus.req_set   = '0;
    bus.req_hit   = 1'b0;
    bus.req_way   = '0;
    bus.req_vmask = '0;
    bus.req_dmask = '0;
    bus.wb_ack    = 1'b0;
    bus.fill_ack  = 1'b0;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else passed++;
  endtask

  // One full transaction; all expectations come from the reference model.
  task automatic run_txn(input int s, input bit hit, input int hway,
                         input logic [3:0] vm, input logic [3:0] dm,
                         input int wb_dly, input int fill_dly, input bit dual,
                         output int got_way, output bit got_ev);
    int exp_way, exp_lat, cyc, wbn, filln;
    bit exp_wb, done, saw_wb, saw_fill, wb_ack_prev, fill_ack_prev;
    got_way = -1;
    got_ev  = 1'b0;
    if (hit) exp_way = hway;
    else begin
      exp_way = -1;
      for (int w = 3; w >= 0; w--) if (!vm[w]) exp_way = w;
      if (exp_way < 0) exp_way = model_lru(s);
    end
    exp_wb  = !hit && vm[exp_way] && dm[exp_way];
    exp_lat = hit ? 0 : 1 + (exp_wb ? wb_dly + 1 : 0) + fill_dly + 1;

    cyc = 0;
    while (bus.req_ready !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      $display("FAIL txn_ready_timeout: req_ready=%b after %0d cycles", bus.req_ready, cyc);
      return;
    end
    passed++;

    bus.req_valid = 1'b1;
    bus.req_set   = SET_W'(s);
    bus.req_hit   = hit;
    bus.req_way   = 2'(hway);
    bus.req_vmask = vm;
    bus.req_dmask = dm;
    @(negedge clk);
    bus.req_valid = 1'b0;
    if (bus.req_ready !== 1'b0)
      $display("FAIL txn_busy_ready: got %b expected 0", bus.req_ready);
    checks++;
    if (bus.req_ready === 1'b0) passed++;

    wbn = 0; filln = 0; cyc = 0;
    done = 0; saw_wb = 0; saw_fill = 0; wb_ack_prev = 0; fill_ack_prev = 0;
    while (!done && cyc < 60) begin
      bus.wb_ack   = 1'b0;
      bus.fill_ack = 1'b0;
      if (wb_ack_prev)   cmp("wb_req_drop",   int'(bus.wb_req),   0);
      if (fill_ack_prev) cmp("fill_req_drop", int'(bus.fill_req), 0);
      wb_ack_prev   = 0;
      fill_ack_prev = 0;
      if (bus.wb_req === 1'b1) begin
        if (!saw_wb) begin
          cmp("wb_set", int'(bus.wb_set), s);
          cmp("wb_way", int'(bus.wb_way), exp_way);
          saw_wb = 1;
        end
        wbn++;
        if (wbn == wb_dly + 1) begin
          bus.wb_ack  = 1'b1;
          wb_ack_prev = 1;
          if (dual) bus.fill_ack = 1'b1;
        end
      end
      if (bus.fill_req === 1'b1) begin
        if (!saw_fill) begin
          cmp("fill_set", int'(bus.fill_set), s);
          cmp("fill_way", int'(bus.fill_way), exp_way);
          saw_fill = 1;
        end
        filln++;
        if (filln == fill_dly + 1) begin
          bus.fill_ack  = 1'b1;
          fill_ack_prev = 1;
        end
      end
      if (bus.rsp_valid === 1'b1) begin
        got_way = int'(bus.rsp_way);
        got_ev  = bus.rsp_evict;
        done    = 1;
        cmp("rsp_way",     got_way,     exp_way);
        cmp("rsp_evict",   int'(got_ev), int'(exp_wb));
        cmp("rsp_latency", cyc,         exp_lat);
      end
      @(negedge clk);
      cyc++;
    end
    bus.wb_ack   = 1'b0;
    bus.fill_ack = 1'b0;
    checks++;
    if (!done) begin
      $display("FAIL txn_rsp_timeout: no rsp_valid after %0d cycles (set %0d)", cyc, s);
      return;
    end
    passed++;
    cmp("rsp_pulse_len",  int'(bus.rsp_valid), 0);
    cmp("ready_after",    int'(bus.req_ready), 1);
    cmp("wb_seen",        int'(saw_wb),        int'(exp_wb));
    cmp("fill_seen",      int'(saw_fill),      int'(!hit));
    model_touch(s, exp_way);
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_b = 1'b0;
    repeat (2) @(negedge clk);
    cmp("rst_req_ready", int'(bus.req_ready), 1);
    cmp("rst_rsp_valid", int'(bus.rsp_valid), 0);
    cmp("rst_rsp_way",   int'(bus.rsp_way),   0);
    cmp("rst_rsp_evict", int'(bus.rsp_evict), 0);
    cmp("rst_wb_req",    int'(bus.wb_req),    0);
    cmp("rst_fill_req",  int'(bus.fill_req),  0);
    cmp("rst_wb_loc",    int'({bus.wb_set, bus.wb_way}),     0);
    cmp("rst_fill_loc",  int'({bus.fill_set, bus.fill_way}), 0);
`ifdef CACHE_REPL_PERF_EN
    cmp("rst_hit_cnt",  int'(hit_cnt),  0);
    cmp("rst_miss_cnt", int'(miss_cnt), 0);
    cmp("rst_wb_cnt",   int'(wb_cnt),   0);
`endif
    rst_b = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_cold_miss();
    int w; bit ev;
    run_txn(0, 0, 0, 4'b0000, 4'b0000, 0, 2, 0, w, ev);
    cmp("cold_way", w, 0);
    cmp("cold_evict", int'(ev), 0);
  endtask

  task automatic test_lru_order();
    int w; bit ev;
    for (int i = 0; i < 4; i++) run_txn(5, 1, i, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(5, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    cmp("lru_victim_way0", w, 0);
    for (int i = 0; i < 4; i++) run_txn(6, 1, i, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(6, 1, 0, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(6, 0, 0, 4'b1111, 4'b0000, 0, 1, 0, w, ev);
    cmp("lru_victim_way1", w, 1);
  endtask

  task automatic test_dirty_evict();
    int w; bit ev;
    run_txn(3, 0, 0, 4'b1111, 4'b1111, 3, 1, 0, w, ev);
    cmp("dirty_way", w, 3);
    cmp("dirty_evict", int'(ev), 1);
  endtask

  task automatic test_hit_latency();
    int w; bit ev;
    run_txn(10, 1, 2, 4'b0000, 4'b0000, 0, 0, 0, w, ev);
    cmp("hit_way", w, 2);
    bus.fill_ack = 1'b1;
    bus.wb_ack   = 1'b1;
    repeat (2) begin
      @(negedge clk);
      cmp("stray_ack_fill_req", int'(bus.fill_req),  0);
      cmp("stray_ack_rsp",      int'(bus.rsp_valid), 0);
      cmp("stray_ack_ready",    int'(bus.req_ready), 1);
    end
    bus.fill_ack = 1'b0;
    bus.wb_ack   = 1'b0;
    run_txn(10, 0, 0, 4'b1011, 4'b0000, 0, 1, 0, w, ev);
    cmp("after_stray_way", w, 2);
  endtask

  task automatic test_dual_ack();
    int w; bit ev;
    run_txn(12, 0, 0, 4'b1111, 4'b1111, 1, 0, 1, w, ev);
    cmp("dual_evict", int'(ev), 1);
  endtask

  task automatic test_reset_mid_wb();
    int w, cyc; bit ev, saw_rsp;
    run_txn(9, 1, 3, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    bus.req_valid = 1'b1;
    bus.req_set   = SET_W'(9);
    bus.req_hit   = 1'b0;
    bus.req_vmask = 4'b1111;
    bus.req_dmask = 4'b1111;
    @(negedge clk);
    bus.req_valid = 1'b0;
    cyc = 0;
    while (bus.wb_req !== 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    cmp("midwb_wb_req_seen", int'(bus.wb_req), 1);
    cmp("midwb_wb_way", int'(bus.wb_way), model_lru(9));
    @(negedge clk);
    rst_b = 1'b0;
    #1;
    cmp("midwb_wb_req_drop", int'(bus.wb_req),    0);
    cmp("midwb_ready",       int'(bus.req_ready), 1);
    cmp("midwb_rsp",         int'(bus.rsp_valid), 0);
    @(negedge clk);
    rst_b = 1'b1;
    model_reset();
    saw_rsp = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid === 1'b1) saw_rsp = 1;
    end
    cmp("midwb_no_rsp", int'(saw_rsp), 0);
    run_txn(9, 0, 0, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    cmp("midwb_reinit_victim", w, 3);
  endtask

  task automatic test_random();
    int w, s, hw; bit ev, hit;
    for (int i = 0; i < 40; i++) begin
      s   = int'($urandom_range(16, 19));
      hit = 1'($urandom_range(0, 1));
      hw  = int'($urandom_range(0, 3));
      run_txn(s, hit, hw, 4'($urandom), 4'($urandom),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), w, ev);
    end
  endtask

`ifdef CACHE_REPL_PERF_EN
  task automatic test_perf();
    int w; bit ev;
    logic [31:0] h0, m0, b0;
    h0 = hit_cnt; m0 = miss_cnt; b0 = wb_cnt;
    run_txn(20, 1, 1, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(20, 1, 2, 4'b1111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(21, 0, 0, 4'b0111, 4'b0000, 0, 0, 0, w, ev);
    run_txn(22, 0, 0, 4'b1111, 4'b1111, 0, 0, 0, w, ev);
    cmp("perf_hit_cnt",  int'(hit_cnt - h0),  2);
    cmp("perf_miss_cnt", int'(miss_cnt - m0), 2);
    cmp("perf_wb_cnt",   int'(wb_cnt - b0),   1);
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_cold_miss();
    test_lru_order();
    test_dirty_evict();
    test_hit_latency();
    test_dual_ack();
    test_reset_mid_wb();
    test_random();
`ifdef CACHE_REPL_PERF_EN
    test_perf();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
